// File: rtl/prog_mem_loader.sv
// -----------------------------------------------------------------------------
// prog_mem_loader
//   Fills program memory from a byte stream. The stream is a 16-bit word
//   count N (LSB first), then N 32-bit words, each sent LSB first. Every
//   completed word becomes a one-cycle word write at byte address
//   BASE_ADDR + 4*index. The loader owns the memory image from reset until
//   the load finishes (done) or aborts (error).
//
//   Optional feature (macro CHECKSUM_EN): the data words are followed by a
//   4-byte little-endian checksum. The checksum is the 32-bit wrapping sum
//   of all data words. A match ends in done; a mismatch ends in error.
//   Words that were already written stay in memory.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_start     one-cycle pulse that arms the loader (ignored while busy)
//   i_rx_data   stream byte
//   i_rx_valid  i_rx_data is valid
//   o_rx_ready  loader takes a byte on this cycle's edge
//   o_mem_we    word write strobe, one cycle per word
//   o_mem_addr  byte address of the write
//   o_mem_data  write word
//   o_busy      load in progress
//   o_done      load completed; stays set until the next start
//   o_error     load aborted or failed; stays set until the next start
//   o_word_cnt  number of words written so far
// -----------------------------------------------------------------------------
module prog_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH-2:0] o_word_cnt
);

  localparam int CW = ADDR_WIDTH - 1;
  // A full memory holds 2**(ADDR_WIDTH-2) words. A longer stream is rejected.
  localparam logic [16:0] CAP = 17'(2 ** (ADDR_WIDTH - 2));
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
`ifdef CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t r_state, w_state_nx;

  logic [7:0]            r_len_lo;
  logic [CW-1:0]         r_len;
  logic [31:0]           r_word;
  logic [1:0]            r_byte_idx;
  logic [CW-1:0]         r_word_cnt;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
`ifdef CHECKSUM_EN
  logic [31:0]           r_csum;
`endif

  logic                  w_fire;
  logic                  w_start_ok;
  logic [15:0]           w_len;
  logic                  w_len_big;
  logic [31:0]           w_word_next;
  logic                  w_byte4;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_fire      = i_rx_valid && o_rx_ready;
  assign w_start_ok  = i_start && (r_state == S_IDLE || r_state == S_DONE ||
                                   r_state == S_ERROR);
  assign w_len       = {i_rx_data, r_len_lo};
  assign w_len_big   = {1'b0, w_len} > CAP;
  // Bytes arrive LSB first: shift in from the top, so after four bytes the
  // first byte sits in [7:0].
  assign w_word_next = {i_rx_data, r_word[31:8]};
  assign w_byte4     = w_fire && (r_byte_idx == 2'd3);
  assign w_cnt_inc   = r_word_cnt + CW'(1);
  assign w_last      = (w_cnt_inc == r_len);
  // The top count bit is dropped here. It can only be set once the memory is
  // full, and the capacity check guarantees no write happens after that.
  assign w_addr      = BASE + {r_word_cnt[CW-2:0], 2'b00};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // ---------------------------------------------------------------------------
  // Next state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    o_rx_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_error    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_fire) w_state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_fire) begin
          if (w_len_big)
            w_state_nx = S_ERROR;
          else if (w_len == 16'd0)
`ifdef CHECKSUM_EN
            w_state_nx = S_CSUM;
`else
            w_state_nx = S_DONE;
`endif
          else
            w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        // Ready stays high while the previous word's write goes out, so the
        // byte stream never stalls.
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_byte4 && w_last)
`ifdef CHECKSUM_EN
          w_state_nx = S_CSUM;
`else
          w_state_nx = S_DONE;
`endif
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_byte4)
          w_state_nx = (w_word_next == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) w_state_nx = S_LEN_LO;
      end
      S_ERROR: begin
        o_error = 1'b1;
        if (i_start) w_state_nx = S_LEN_LO;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: length capture, word assembly, write issue, checksum
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_word     <= '0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
`ifdef CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      // Start is only taken when no byte can be consumed, so it never
      // collides with the byte path below.
      if (w_start_ok) begin
        r_word     <= '0;
        r_byte_idx <= '0;
        r_word_cnt <= '0;
`ifdef CHECKSUM_EN
        r_csum     <= '0;
`endif
      end
      if (w_fire) begin
        case (r_state)
          S_LEN_LO: r_len_lo <= i_rx_data;
          // Only the low bits are kept. A length that needs more bits is
          // rejected, so the stored value is never used in that case.
          S_LEN_HI: r_len <= w_len[CW-1:0];
          S_DATA: begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // The address comes from the pre-increment count. The count
              // shows its new value while the strobe is high.
              r_mem_we   <= 1'b1;
              r_mem_data <= DATA_WIDTH'(w_word_next);
              r_mem_addr <= w_addr;
              r_word_cnt <= w_cnt_inc;
`ifdef CHECKSUM_EN
              r_csum     <= r_csum + w_word_next;
`endif
            end
          end
`ifdef CHECKSUM_EN
          S_CSUM: begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_prog_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_loader
//   Directed bench for prog_mem_loader with the default parameters
//   (ADDR_WIDTH=10, BASE_ADDR=0). The checksum scenarios are compiled in when
//   CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_prog_mem_loader;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_mem_we;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_data;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [8:0]  o_word_cnt;

  prog_mem_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BASE_ADDR(0)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_error    (o_error),
    .o_word_cnt (o_word_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;
  int n_fire = 0;
  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  // Record every write and every consumed byte half a cycle after the edge.
  always @(negedge i_clk) begin
    if (o_mem_we === 1'b1) begin
      wa.push_back(o_mem_addr);
      wd.push_back(o_mem_data);
    end
    if (i_rx_valid && o_rx_ready === 1'b1) n_fire++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Offer one byte and hold it until it is taken (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    while (o_rx_ready !== 1'b1 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) chk("rdy_timeout", {31'd0, o_rx_ready}, 32'd1);
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  // Scenario 1: two words 0x00000013 and 0x00100093. The gap option idles
  // rx_valid after every byte. The start option pulses start mid-load, which
  // must be ignored.
  task automatic run_load(input string tag, input bit gap, input bit start_mid);
    logic [7:0] s[$];
    int f0;
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef CHECKSUM_EN
    // 0x00000013 + 0x00100093 = 0x001000A6
    s.push_back(8'hA6); s.push_back(8'h00); s.push_back(8'h10); s.push_back(8'h00);
`endif
    wa.delete(); wd.delete();
    do_start();
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
    f0 = n_fire;
    foreach (s[i]) begin
      send_byte(s[i]);
      if (gap) begin
        if (start_mid && i == 5) i_start = 1'b1;
        tick();
        i_start = 1'b0;
      end
    end
    tick();
    chk({tag, "_nwr"},   wa.size(), 2);
    chk({tag, "_a0"},    {22'd0, wa[0]}, 32'h000);
    chk({tag, "_d0"},    wd[0], 32'h0000_0013);
    chk({tag, "_a1"},    {22'd0, wa[1]}, 32'h004);
    chk({tag, "_d1"},    wd[1], 32'h0010_0093);
    chk({tag, "_cnt"},   {23'd0, o_word_cnt}, 32'd2);
    chk({tag, "_done"},  {31'd0, o_done}, 32'd1);
    chk({tag, "_err"},   {31'd0, o_error}, 32'd0);
    chk({tag, "_busy0"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_fires"}, n_fire - f0, s.size());
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  {31'd0, o_rx_ready}, 32'd0);
    chk({tag, "_we"},   {31'd0, o_mem_we}, 32'd0);
    chk({tag, "_addr"}, {22'd0, o_mem_addr}, 32'd0);
    chk({tag, "_data"}, o_mem_data, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_err"},  {31'd0, o_error}, 32'd0);
    chk({tag, "_cnt"},  {23'd0, o_word_cnt}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    i_rst_n = 1'b0; i_start = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0;
    repeat (3) tick();
    chk_all_zero("rst");
    i_rst_n = 1'b1;
    tick();

    // 1: basic two-word load
    run_load("t1", 1'b0, 1'b0);

    // 2: N=257 exceeds 256-word capacity
    wa.delete(); wd.delete();
    do_start();
    send_seq('{8'h01, 8'h01});
    chk("t2_err",  {31'd0, o_error}, 32'd1);
    chk("t2_rdy",  {31'd0, o_rx_ready}, 32'd0);
    chk("t2_busy", {31'd0, o_busy}, 32'd0);
    chk("t2_done", {31'd0, o_done}, 32'd0);
    repeat (3) tick();
    chk("t2_nwr",  wa.size(), 0);
    run_load("t2r", 1'b0, 1'b0);

    // 3: bytes offered while not ready are left alone; gapped stream with a
    //    start pulse during DATA
    f0 = n_fire;
    i_rx_data = 8'hAA; i_rx_valid = 1'b1;
    repeat (3) tick();
    i_rx_valid = 1'b0;
    chk("t3_nofire", n_fire - f0, 0);
    chk("t3_done_kept", {31'd0, o_done}, 32'd1);
    run_load("t3", 1'b1, 1'b1);
    f0 = n_fire;
    i_rx_data = 8'h55; i_rx_valid = 1'b1;
    repeat (2) tick();
    i_rx_valid = 1'b0;
    chk("t3_nofire2", n_fire - f0, 0);

    // 4: reset mid-word, then reset beating start, then a clean rerun
    do_start();
    send_seq('{8'h02, 8'h00, 8'h13, 8'h00});
    i_rst_n = 1'b0;
    tick();
    chk_all_zero("t4");
    i_start = 1'b1;
    tick();
    i_start = 1'b0; i_rst_n = 1'b1;
    tick();
    chk("t4_start_in_rst", {31'd0, o_busy}, 32'd0);
    run_load("t4r", 1'b0, 1'b0);

    // 5: empty program
    wa.delete(); wd.delete();
    do_start();
    send_seq('{8'h00, 8'h00});
`ifdef CHECKSUM_EN
    chk("t5_csum_busy", {31'd0, o_busy}, 32'd1);
    send_seq('{8'h00, 8'h00, 8'h00, 8'h00});
`endif
    chk("t5_done", {31'd0, o_done}, 32'd1);
    chk("t5_cnt",  {23'd0, o_word_cnt}, 32'd0);
    tick();
    chk("t5_nwr",  wa.size(), 0);

`ifdef CHECKSUM_EN
    // 6: checksum match and mismatch
    wa.delete(); wd.delete();
    do_start();
    send_seq('{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00});
    tick();
    chk("t6_done", {31'd0, o_done}, 32'd1);
    chk("t6_err",  {31'd0, o_error}, 32'd0);
    wa.delete(); wd.delete();
    do_start();
    send_seq('{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00});
    tick();
    chk("t6b_err",  {31'd0, o_error}, 32'd1);
    chk("t6b_done", {31'd0, o_done}, 32'd0);
    chk("t6b_nwr",  wa.size(), 1);
    chk("t6b_a0",   {22'd0, wa[0]}, 32'h000);
    chk("t6b_d0",   wd[0], 32'h0000_0013);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
